// File: rtl/fractal_sync_arbiter.sv
// Round-robin arbiter that lets N_REQ local requesters share one fractal-sync tree slave port.
// Optional statistics counters are built when FRACTAL_SYNC_ARBITER_STATS_EN is defined.
module fractal_sync_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned LVL_WIDTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [N_REQ*LVL_WIDTH-1:0]   req_level_i,
    output logic [N_REQ-1:0]             rsp_valid_o,
    output logic                         rsp_error_o,
    output logic                         fab_sync_o,
    output logic [LVL_WIDTH-1:0]         fab_level_o,
    output logic                         fab_ack_o,
    input  logic                         fab_wake_i,
    input  logic                         fab_error_i,
    output logic [15:0]                  sync_cnt_o,
    output logic [15:0]                  err_cnt_o,
    output logic [2:0]                   dbg_state_o
);

    // Handshake: a requester holds req_i until its one-cycle rsp_valid_o pulse; the tree sees a
    // one-cycle fab_sync_o, answers with fab_wake_i held until our one-cycle fab_ack_o, then drops it.
    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          last_grant_q;
    logic [LVL_WIDTH-1:0]   level_q;
    logic                   error_q;

    logic [LVL_WIDTH-1:0]   lvl_arr [N_REQ];
    logic [GW-1:0]          rr_idx;
    logic [GW-1:0]          cand;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lvl_arr[i] = req_level_i[i*LVL_WIDTH +: LVL_WIDTH];
        end
    end

    // Scan downward so the candidate closest after last_grant_q is the one that sticks.
    always_comb begin
        rr_idx = '0;
        cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = GW'((int'(last_grant_q) + k) % int'(N_REQ));
            if (req_i[cand]) begin
                rr_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req_i)      state_d = ST_SYNC;
            ST_SYNC:                   state_d = ST_WAIT;
            ST_WAIT:  if (fab_wake_i)  state_d = ST_ACK;
            ST_ACK:                    state_d = ST_DRAIN;
            ST_DRAIN: if (!fab_wake_i) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            grant_q      <= '0;
            level_q      <= '0;
            error_q      <= 1'b0;
            last_grant_q <= GW'(N_REQ - 1);
        end else begin
            if (state_q == ST_IDLE && |req_i) begin
                grant_q <= rr_idx;
                level_q <= lvl_arr[rr_idx];
            end
            if (state_q == ST_WAIT && fab_wake_i) begin
                error_q <= fab_error_i;
            end
            if (state_q == ST_ACK) begin
                last_grant_q <= grant_q;
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_error_o = 1'b0;
        fab_sync_o  = 1'b0;
        fab_level_o = '0;
        fab_ack_o   = 1'b0;
        case (state_q)
            ST_SYNC: begin
                fab_sync_o  = 1'b1;
                fab_level_o = level_q;
            end
            ST_ACK: begin
                fab_ack_o            = 1'b1;
                rsp_valid_o[grant_q] = 1'b1;
                rsp_error_o          = error_q;
            end
            default: ;
        endcase
    end

    assign dbg_state_o = state_q;

`ifdef FRACTAL_SYNC_ARBITER_STATS_EN
    logic [15:0] sync_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (state_q == ST_ACK) begin
            if (sync_cnt_q != 16'hFFFF) sync_cnt_q <= sync_cnt_q + 16'd1;
            if (error_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign sync_cnt_o = sync_cnt_q;
    assign err_cnt_o  = err_cnt_q;
`else
    assign sync_cnt_o = '0;
    assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_arbiter.sv
// Scoreboard bench for fractal_sync_arbiter: random requesters and a random tree responder,
// checked against a round-robin reference model.
module tb_fractal_sync_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;

    logic              clk;
    logic              rstn;
    logic [N-1:0]      req;
    logic [N*LW-1:0]   req_level;
    logic [N-1:0]      rsp_valid_o;
    logic              rsp_error_o;
    logic              fab_sync_o;
    logic [LW-1:0]     fab_level_o;
    logic              fab_ack_o;
    logic              fab_wake;
    logic              fab_error;
    logic [15:0]       sync_cnt_o;
    logic [15:0]       err_cnt_o;
    logic [2:0]        dbg_state_o;

    fractal_sync_arbiter #(.N_REQ(N), .LVL_WIDTH(LW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_i       (req),
        .req_level_i (req_level),
        .rsp_valid_o (rsp_valid_o),
        .rsp_error_o (rsp_error_o),
        .fab_sync_o  (fab_sync_o),
        .fab_level_o (fab_level_o),
        .fab_ack_o   (fab_ack_o),
        .fab_wake_i  (fab_wake),
        .fab_error_i (fab_error),
        .sync_cnt_o  (sync_cnt_o),
        .err_cnt_o   (err_cnt_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q [$];
    logic [0:0] err_q [$];

    int  grant_cnt [N];
    int  rsp_cnt   [N];
    int  total_rsp = 0;

    int  mode = 0;               // 0: hold fixed pattern, 1: random requesters
    logic [N-1:0]    hold_req;
    logic [N*LW-1:0] hold_lvl;
    logic resp_en  = 1'b1;
    logic spur_go  = 1'b0;
    logic spur_done = 1'b0;

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ---------------- requester driver ----------------
    initial begin
        int seen_g [N];
        int seen_r [N];
        req = '0;
        req_level = '0;
        for (int i = 0; i < N; i++) begin seen_g[i] = 0; seen_r[i] = 0; end
        forever begin
            @(posedge clk); #1;
            if (mode == 0) begin
                req = hold_req;
                req_level = hold_lvl;
                for (int i = 0; i < N; i++) begin seen_g[i] = grant_cnt[i]; seen_r[i] = rsp_cnt[i]; end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (rsp_cnt[i] != seen_r[i]) begin
                        seen_r[i] = rsp_cnt[i];
                        seen_g[i] = grant_cnt[i];
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                        else req_level[i*LW +: LW] = LW'($urandom_range(0, 15));
                    end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_level[i*LW +: LW] = LW'($urandom_range(0, 15));
                    end else if (req[i] && grant_cnt[i] != seen_g[i]) begin
                        seen_g[i] = grant_cnt[i];
                        if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- tree responder ----------------
    initial begin
        int d, h;
        logic e;
        bit got;
        fab_wake = 1'b0;
        fab_error = 1'b0;
        forever begin
            @(negedge clk);
            if (spur_go && !spur_done) begin
                @(posedge clk); #1;
                fab_wake = 1'b1; fab_error = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                fab_wake = 1'b0; fab_error = 1'b0;
                spur_done = 1'b1;
            end else if (resp_en && rstn && fab_sync_o) begin
                d = $urandom_range(0, 4);
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                e = ($urandom_range(0, 2) == 0);
                fab_wake = 1'b1; fab_error = e;
                err_q.push_back(e);
                got = 0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(negedge clk);
                    if (fab_ack_o) got = 1;
                end
                if (!got) begin
                    checks++; errors++;
                    $display("FAIL ack_timeout got no fab_ack_o within 20 cycles, expected one");
                end
                h = $urandom_range(0, 6);
                repeat (h) @(posedge clk);
                @(posedge clk); #1;
                fab_wake = 1'b0; fab_error = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [N-1:0]    prev_req;
        logic [N*LW-1:0] prev_lvl;
        int   last_model;
        int   model_sync, model_err;
        bit   drain_pending, prev_sync;
        int   g;
        logic [1:0] eg;
        logic [0:0] ee;
        logic [15:0] exp_sc, exp_ec;
        logic [N-1:0] exp_onehot;
        prev_req = '0; prev_lvl = '0; last_model = N - 1;
        model_sync = 0; model_err = 0; drain_pending = 0; prev_sync = 0;
        for (int i = 0; i < N; i++) begin grant_cnt[i] = 0; rsp_cnt[i] = 0; end
        forever begin
            @(negedge clk);
            if (!rstn) begin
                checks++;
                if (rsp_valid_o != '0 || rsp_error_o || fab_sync_o || fab_level_o != '0 || fab_ack_o ||
                    sync_cnt_o != 16'd0 || err_cnt_o != 16'd0) begin
                    errors++;
                    $display("FAIL reset_outputs got sync=%b lvl=%h ack=%b rsp=%b err=%b cnt=%0d/%0d, expected all zero",
                             fab_sync_o, fab_level_o, fab_ack_o, rsp_valid_o, rsp_error_o, sync_cnt_o, err_cnt_o);
                end
                exp_q.delete(); err_q.delete();
                last_model = N - 1; model_sync = 0; model_err = 0;
                drain_pending = 0; prev_sync = 0;
            end else begin
                if (!fab_wake) drain_pending = 0;

                checks++;
                if (!fab_sync_o && fab_level_o != '0) begin
                    errors++; $display("FAIL level_idle got %h expected 0", fab_level_o);
                end
                checks++;
                if (rsp_valid_o == '0 && rsp_error_o) begin
                    errors++; $display("FAIL err_unqualified got 1 expected 0");
                end
                checks++;
                if (fab_ack_o != (rsp_valid_o != '0)) begin
                    errors++; $display("FAIL ack_vs_rsp got ack=%b rsp=%b expected ack equal to any rsp", fab_ack_o, rsp_valid_o);
                end

`ifdef FRACTAL_SYNC_ARBITER_STATS_EN
                exp_sc = (model_sync > 65535) ? 16'hFFFF : 16'(model_sync);
                exp_ec = (model_err  > 65535) ? 16'hFFFF : 16'(model_err);
`else
                exp_sc = 16'd0;
                exp_ec = 16'd0;
`endif
                checks++;
                if (sync_cnt_o != exp_sc || err_cnt_o != exp_ec) begin
                    errors++;
                    $display("FAIL stats got %0d/%0d expected %0d/%0d", sync_cnt_o, err_cnt_o, exp_sc, exp_ec);
                end

                if (fab_sync_o) begin
                    g = rr_pick(prev_req, last_model);
                    checks++;
                    if (g < 0 || exp_q.size() != 0 || drain_pending || prev_sync) begin
                        errors++;
                        $display("FAIL sync_allowed got sync with req=%b outstanding=%0d drain=%0b prev_sync=%0b, expected none",
                                 prev_req, exp_q.size(), drain_pending, prev_sync);
                    end
                    if (g >= 0) begin
                        checks++;
                        if (fab_level_o != prev_lvl[g*LW +: LW]) begin
                            errors++;
                            $display("FAIL sync_level got %h expected %h (requester %0d)", fab_level_o, prev_lvl[g*LW +: LW], g);
                        end
                        exp_q.push_back(2'(g));
                        grant_cnt[g]++;
                        last_model = g;
                    end
                end

                if (rsp_valid_o != '0) begin
                    checks++;
                    if (exp_q.size() == 0 || err_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected got rsp=%b expected no response", rsp_valid_o);
                    end else begin
                        eg = exp_q.pop_front();
                        ee = err_q.pop_front();
                        exp_onehot = '0;
                        exp_onehot[eg] = 1'b1;
                        if (rsp_valid_o != exp_onehot || rsp_error_o != ee[0]) begin
                            errors++;
                            $display("FAIL rsp_grant got rsp=%b err=%b expected rsp=%b err=%b", rsp_valid_o, rsp_error_o, exp_onehot, ee[0]);
                        end
                        rsp_cnt[eg]++;
                        model_sync++;
                        if (ee[0]) model_err++;
                    end
                    total_rsp++;
                    drain_pending = 1;
                end
                prev_sync = fab_sync_o;
            end
            prev_req = req;
            prev_lvl = req_level;
        end
    end

    // ---------------- main sequence ----------------
    task automatic wait_rsp(input int n, input int budget, input string name);
        int target;
        target = total_rsp + n;
        for (int k = 0; k < budget && total_rsp < target; k++) @(negedge clk);
        if (total_rsp < target) begin
            checks++; errors++;
            $display("FAIL %s got %0d responses expected %0d", name, total_rsp - (target - n), n);
        end
    endtask

    task automatic quiesce();
        mode = 0;
        hold_req = '0;
        repeat (40) @(posedge clk);
        #2;
    endtask

    initial begin
        bit got;
        rstn = 1'b0;
        hold_req = '1;
        for (int i = 0; i < N; i++) hold_lvl[i*LW +: LW] = LW'($urandom_range(0, 15));
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // all requesters held from reset: grant order 0,1,2,3,0
        wait_rsp(5, 300, "all_req_rr");
        quiesce();

        // single request with level 3
        hold_lvl = '0;
        hold_lvl[1*LW +: LW] = 4'h3;
        hold_req = 4'b0010;
        wait_rsp(1, 60, "single_req");
        quiesce();

        // wake in IDLE must be ignored
        spur_go = 1'b1;
        for (int k = 0; k < 20 && !spur_done; k++) @(negedge clk);
        checks++;
        if (!spur_done) begin errors++; $display("FAIL spur_wake got no pulse expected pulse issued"); end
        repeat (8) @(posedge clk);
        #2;

        // random traffic
        mode = 1;
        repeat (700) @(posedge clk);
        quiesce();

        // reset during WAIT
        resp_en = 1'b0;
        hold_req = 4'b0110;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (fab_sync_o) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL pre_reset_sync got no sync expected one"); end
        repeat (2) @(posedge clk);
        #2;
        hold_req = 4'b0111;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resp_en = 1'b1;
        rstn = 1'b1;
        wait_rsp(2, 80, "post_reset");

        mode = 1;
        repeat (300) @(posedge clk);
        quiesce();

        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL drain_end got %0d outstanding expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fractal_sync_arbiter.md
FRACTAL_SYNC_ARBITER -- requirements
Module: fractal_sync_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of local requesters sharing one tree slave port (range 2..16).
REQ-002 SHALL have parameter LVL_WIDTH, default 4, width of the synchronization level field.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rstn_i  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port req_i  input  N_REQ  per-requester sync request, held high until the matching response.
REQ-006 SHALL have port req_level_i  input  N_REQ*LVL_WIDTH  per-requester level, slice i is bits [i*LVL_WIDTH +: LVL_WIDTH].
REQ-007 SHALL have port rsp_valid_o  output  N_REQ  one-hot, single-cycle completion pulse.
REQ-008 SHALL have port rsp_error_o  output  1  error flag, qualified by any rsp_valid_o bit.
REQ-009 SHALL have port fab_sync_o  output  1  sync request to the tree slave port.
REQ-010 SHALL have port fab_level_o  output  LVL_WIDTH  level presented with fab_sync_o.
REQ-011 SHALL have port fab_ack_o  output  1  acknowledge to the tree slave port.
REQ-012 SHALL have port fab_wake_i  input  1  wake from the tree slave port.
REQ-013 SHALL have port fab_error_i  input  1  error from the tree, valid while fab_wake_i=1.
REQ-014 SHALL have ports sync_cnt_o and err_cnt_o  output  16 each  statistics counters (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE -> SYNC -> WAIT -> ACK -> DRAIN -> IDLE, with one operation in flight at a time.
REQ-016 IDLE: when any req_i bit is set, SHALL grant round-robin, searching from (last_grant+1) mod N_REQ upward, latch the grant index and its level, and go to SYNC.
REQ-017 SYNC: SHALL drive fab_sync_o=1 and fab_level_o=latched level for exactly one cycle, then go to WAIT; the latency from req_i high in IDLE to fab_sync_o high SHALL be 1 cycle.
REQ-018 WAIT: SHALL hold until fab_wake_i=1, then latch fab_error_i and go to ACK; there is no timeout.
REQ-019 ACK: SHALL drive fab_ack_o=1, rsp_valid_o[grant]=1 and rsp_error_o=latched error for exactly one cycle, update last_grant, and go to DRAIN.
REQ-020 DRAIN: SHALL hold until fab_wake_i=0, then go to IDLE; no new grant is issued while fab_wake_i=1.
REQ-021 fab_level_o SHALL be 0 outside SYNC, and rsp_error_o SHALL be 0 when no rsp_valid_o bit is set.
REQ-022 req_i is sampled only in IDLE; deassertion after grant SHALL NOT abort the operation, and the response pulse is still issued.
REQ-023 A requester still asserting req_i after its response SHALL be treated as a new request at lower priority than the other requesters.
REQ-024 fab_wake_i=1 observed in IDLE or SYNC SHALL be ignored.
REQ-025 The grant index SHALL use $clog2(N_REQ) bits, and the round-robin SHALL wrap from N_REQ-1 to 0.

Reset
REQ-026 While rstn_i=0: state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority), all outputs 0, counters 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation without issuing a response pulse.

Configuration
REQ-028 Macro FRACTAL_SYNC_ARBITER_STATS_EN defined: sync_cnt_o SHALL increment on every ACK cycle, and err_cnt_o SHALL increment on ACK cycles with latched error=1; both counters saturate at 16'hFFFF.
REQ-029 Macro FRACTAL_SYNC_ARBITER_STATS_EN undefined: no counter flops, and sync_cnt_o and err_cnt_o SHALL be tied to 0.

Verification
REQ-030 Single request: req_i=4'b0010, level 4'h3, wake returned 3 cycles after sync -> fab_sync_o one cycle with level 3, then fab_ack_o and rsp_valid_o=4'b0010 together, rsp_error_o=0.
REQ-031 All requesters asserted continuously from reset -> grant order 0,1,2,3,0, one operation at a time.
REQ-032 fab_error_i=1 with wake -> rsp_error_o=1 on the pulse; with STATS_EN defined, err_cnt_o=1 and sync_cnt_o=1.
REQ-033 fab_wake_i held high 5 cycles after ack -> arbiter stays in DRAIN, with no fab_sync_o until wake falls.
REQ-034 rstn_i pulsed low during WAIT -> all outputs 0, no rsp_valid_o; the next grant goes to requester 0.
REQ-035 req_i[2] dropped the cycle after grant -> operation still completes, and rsp_valid_o[2] pulses.
